// File: rtl/led_colour_sequencer.sv
// led_colour_sequencer: per-channel RGB code stepper driven by button edges or a prescaled tick.
// Optional button debounce filter enabled by defining DEBOUNCE_EN.
module led_colour_sequencer #(
    parameter int N_CH         = 2,
    parameter int COLOUR_W     = 3,
    parameter int PRESCALE     = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            button,
    input  logic [N_CH-1:0]            off,
    input  logic                       dir,
    input  logic                       auto_en,
    output logic [N_CH*COLOUR_W-1:0]   colour,
    output logic [N_CH-1:0]            on_off
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [COLOUR_W-1:0] MAX = COLOUR_W'((1 << COLOUR_W) - 2);
    localparam logic [COLOUR_W-1:0] ONE = COLOUR_W'(1);
    typedef enum logic {OFF, RUN} state_t;
    logic [N_CH-1:0]     btn_d1, rise;
    logic [PW-1:0]       pcnt;
    logic                tick;
    state_t              st  [N_CH];
    logic [COLOUR_W-1:0] col [N_CH];
    always_ff @(posedge clk)
        btn_d1 <= rst ? '0 : button;
`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    logic [DW-1:0]   dcnt [N_CH];
    logic [N_CH-1:0] stable, stable_q;
    // stable flips only after btn_d1 has disagreed with it for DEBOUNCE_CYC edges in a row
    always_ff @(posedge clk) begin
        if (rst) begin
            stable   <= '0;
            stable_q <= '0;
            for (int c = 0; c < N_CH; c++) dcnt[c] <= '0;
        end else begin
            stable_q <= stable;
            for (int c = 0; c < N_CH; c++) begin
                if (btn_d1[c] == stable[c]) dcnt[c] <= '0;
                else if (dcnt[c] == DW'(DEBOUNCE_CYC - 1)) begin
                    stable[c] <= ~stable[c];
                    dcnt[c]   <= '0;
                end else dcnt[c] <= dcnt[c] + 1'b1;
            end
        end
    end
    assign rise = stable & ~stable_q;
`else
    logic [N_CH-1:0] btn_d2;
    always_ff @(posedge clk)
        btn_d2 <= rst ? '0 : btn_d1;
    assign rise = btn_d1 & ~btn_d2;
`endif
    assign tick = auto_en && pcnt == PW'(PRESCALE - 1);
    always_ff @(posedge clk)
        pcnt <= (rst || !auto_en || tick) ? '0 : pcnt + 1'b1;
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (rst || off[c]) begin
                st[c]  <= OFF;
                col[c] <= '0;
            end else if (st[c] == OFF && rise[c]) begin
                st[c]  <= RUN;
                col[c] <= ONE;
            end else if (st[c] == RUN && (rise[c] || tick))
                col[c] <= dir ? (col[c] == MAX ? ONE : col[c] + 1'b1)
                              : (col[c] == ONE ? MAX : col[c] - 1'b1);
        end
    end
    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_out
            assign colour[i*COLOUR_W +: COLOUR_W] = col[i];
            assign on_off[i] = st[i] == RUN;
        end
    endgenerate
endmodule

// File: tb/tb_led_colour_sequencer.sv
// tb_led_colour_sequencer: table-driven directed checks plus reset and debounce sequences.
module tb_led_colour_sequencer;
    logic       clk = 0;
    logic       rst = 1;
    logic [1:0] button = '0;
    logic [1:0] off = '0;
    logic       dir = 1;
    logic       auto_en = 0;
    logic [5:0] colour;
    logic [1:0] on_off;
    int         n_chk = 0;
    int         n_fail = 0;
    typedef struct {
        logic [1:0] btn;
        logic [1:0] off;
        logic       dir;
        logic       auto_en;
        logic       rst;
        int         c0;
        int         c1;
        int         oo;
    } vec_t;
    vec_t tv[$];
    led_colour_sequencer #(.N_CH(2), .COLOUR_W(3), .PRESCALE(4), .DEBOUNCE_CYC(8)) dut (
        .clk(clk), .rst(rst), .button(button), .off(off), .dir(dir),
        .auto_en(auto_en), .colour(colour), .on_off(on_off)
    );
    always #5 clk = ~clk;
    task automatic add(input logic [1:0] b, input logic [1:0] o, input logic d, input logic a,
                       input logic r, input int c0, input int c1, input int oo);
        vec_t v;
        v.btn = b; v.off = o; v.dir = d; v.auto_en = a; v.rst = r;
        v.c0 = c0; v.c1 = c1; v.oo = oo;
        tv.push_back(v);
    endtask
    task automatic step(input logic [1:0] b, input logic [1:0] o, input logic d, input logic a,
                        input logic r);
        button = b; off = o; dir = d; auto_en = a; rst = r;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic chk_all(input string nm, input int c0, input int c1, input int oo);
        chk({nm, " colour0"}, int'(colour[2:0]), c0);
        chk({nm, " colour1"}, int'(colour[5:3]), c1);
        chk({nm, " on_off"}, int'(on_off), oo);
    endtask
    initial begin
`ifndef DEBOUNCE_EN
        // btn, off, dir, auto, rst, exp colour0, exp colour1, exp on_off
        add(0, 0, 1, 0, 1, 0, 0, 0);  add(0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);  add(0, 0, 1, 0, 0, 1, 0, 1);
        add(1, 0, 1, 0, 0, 1, 0, 1);  add(0, 0, 1, 0, 0, 2, 0, 1);
        add(1, 0, 1, 0, 0, 2, 0, 1);  add(0, 0, 1, 0, 0, 3, 0, 1);
        add(1, 0, 1, 0, 0, 3, 0, 1);  add(0, 0, 1, 0, 0, 4, 0, 1);
        add(1, 0, 1, 0, 0, 4, 0, 1);  add(0, 0, 1, 0, 0, 5, 0, 1);
        add(1, 0, 1, 0, 0, 5, 0, 1);  add(0, 0, 1, 0, 0, 6, 0, 1);
        add(1, 0, 1, 0, 0, 6, 0, 1);  add(0, 0, 1, 0, 0, 1, 0, 1);
        add(1, 0, 1, 0, 0, 1, 0, 1);  add(0, 0, 1, 0, 0, 2, 0, 1);
        add(1, 0, 1, 0, 0, 2, 0, 1);  add(1, 0, 1, 0, 0, 3, 0, 1);
        add(1, 0, 1, 0, 0, 3, 0, 1);  add(1, 0, 1, 0, 0, 3, 0, 1);
        add(0, 0, 1, 0, 0, 3, 0, 1);
        add(1, 0, 0, 0, 0, 3, 0, 1);  add(0, 0, 0, 0, 0, 2, 0, 1);
        add(1, 0, 0, 0, 0, 2, 0, 1);  add(0, 0, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0, 1);  add(0, 0, 0, 0, 0, 6, 0, 1);
        add(2, 0, 1, 0, 0, 6, 0, 1);  add(0, 0, 1, 0, 0, 6, 1, 3);
        add(0, 2, 1, 0, 0, 6, 0, 1);
        add(0, 0, 1, 1, 0, 6, 0, 1);  add(0, 0, 1, 1, 0, 6, 0, 1);
        add(0, 0, 1, 1, 0, 6, 0, 1);  add(0, 0, 1, 1, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1, 0, 1);  add(0, 0, 1, 1, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1, 0, 1);  add(0, 0, 1, 1, 0, 2, 0, 1);
        add(0, 0, 1, 1, 0, 2, 0, 1);  add(0, 0, 1, 1, 0, 2, 0, 1);
        add(1, 0, 1, 1, 0, 2, 0, 1);  add(0, 0, 1, 1, 0, 3, 0, 1);
        add(0, 0, 1, 1, 0, 3, 0, 1);
        add(1, 1, 1, 1, 0, 0, 0, 0);  add(0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < tv.size(); k++) begin
            step(tv[k].btn, tv[k].off, tv[k].dir, tv[k].auto_en, tv[k].rst);
            chk_all($sformatf("row%0d", k), tv[k].c0, tv[k].c1, tv[k].oo);
        end
        // reset in the middle of an auto run, then prove the prescaler restarted from 0
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_all("rstseq run", 1, 0, 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        chk_all("rstseq reset", 0, 0, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        chk_all("rstseq press", 1, 0, 1);
        step(0, 0, 1, 1, 0);
        chk_all("rstseq pre-tick", 1, 0, 1);
        step(0, 0, 1, 1, 0);
        chk_all("rstseq tick", 2, 0, 1);
`else
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        chk_all("db reset", 0, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 1, 0, 0);
        chk_all("db glitch", 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, 1, 0, 0);
            if (k == 9) chk_all("db edge9", 0, 0, 0);
            if (k == 10) chk_all("db edge10", 1, 0, 1);
        end
        chk_all("db held", 1, 0, 1);
        for (int k = 0; k < 12; k++) step(0, 0, 1, 0, 0);
        chk_all("db release", 1, 0, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
